// File: rtl/npu_definitions.sv
// Shared NPU definitions: broadcast FSM encoding and default block sizes.
package npu_definitions;

    // Default sizing for the vector broadcast unit
    localparam int unsigned DEF_BCAST_DATA_WIDTH = 16;
    localparam int unsigned DEF_BCAST_NUM_LANES  = 16;
    localparam int unsigned DEF_BCAST_REP_WIDTH  = 4;

    // Broadcast FSM states
    typedef enum logic {
        BCAST_IDLE  = 1'b0,
        BCAST_DRIVE = 1'b1
    } bcast_state_e;

endpackage : npu_definitions

// File: rtl/vector_broadcast_unit.sv
// Vector broadcast unit: replicates one captured word onto a set of masked
// output lanes for (repeat+1) beats, with independent per-lane handshakes.
//
// Handshake rule (both sides): a transfer happens in a cycle where valid and
// ready are both high at the rising clock edge. valid never depends
// combinationally on ready. ready_in does depend on ready_out so that a new
// request can be taken on the same cycle the last beat completes.
module vector_broadcast_unit
    import npu_definitions::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_BCAST_DATA_WIDTH,
    parameter int unsigned NUM_LANES  = DEF_BCAST_NUM_LANES,
    parameter int unsigned REP_WIDTH  = DEF_BCAST_REP_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [NUM_LANES-1:0]            lane_mask_in,
    input  logic [REP_WIDTH-1:0]            repeat_in,
    input  logic                            valid_in,
    output logic                            ready_in,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
    output logic [NUM_LANES-1:0]            valid_out,
    input  logic [NUM_LANES-1:0]            ready_out,
    output logic                            beat_done,
    output logic                            busy,
    output bcast_state_e                    dbg_state
);

    localparam logic [REP_WIDTH-1:0] REP_ONE = {{(REP_WIDTH-1){1'b0}}, 1'b1};

    bcast_state_e              r_state;
    bcast_state_e              w_state_nxt;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [DATA_WIDTH-1:0]     w_data_nxt;
    logic [NUM_LANES-1:0]      r_mask;
    logic [NUM_LANES-1:0]      w_mask_nxt;
    logic [NUM_LANES-1:0]      r_pending;
    logic [NUM_LANES-1:0]      w_pending_nxt;
    logic [REP_WIDTH-1:0]      r_rep_cnt;
    logic [REP_WIDTH-1:0]      w_rep_cnt_nxt;

    logic                      w_in_drive;
    logic                      w_beat_complete;
    logic                      w_last_beat;
    logic                      w_accept;
    logic                      w_accept_load;
    logic [NUM_LANES-1:0]      w_still_pending;

    // Handshake status: which pending lanes survive this cycle, and whether
    // the beat (and possibly the whole request) finishes now
    always_comb begin
        w_in_drive      = (r_state == BCAST_DRIVE);
        w_still_pending = r_pending & ~ready_out;
        w_beat_complete = w_in_drive && (w_still_pending == '0);
        w_last_beat     = w_beat_complete && (r_rep_cnt == '0);
        ready_in        = (r_state == BCAST_IDLE) || w_last_beat;
        w_accept        = valid_in && ready_in;
        // An empty-mask request is consumed but has no effect
        w_accept_load   = w_accept && (lane_mask_in != '0);
    end

    // Next-state logic: FSM transitions, pending mask update, capture
    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_mask_nxt    = r_mask;
        w_pending_nxt = r_pending;
        w_rep_cnt_nxt = r_rep_cnt;

        unique case (r_state)
            BCAST_IDLE: begin
                if (w_accept_load) begin
                    w_state_nxt   = BCAST_DRIVE;
                    w_data_nxt    = data_in;
                    w_mask_nxt    = lane_mask_in;
                    w_pending_nxt = lane_mask_in;
                    w_rep_cnt_nxt = repeat_in;
                end
            end
            BCAST_DRIVE: begin
                w_pending_nxt = w_still_pending;
                if (w_beat_complete) begin
                    if (r_rep_cnt != '0) begin
                        // Next beat starts immediately from the captured mask
                        w_rep_cnt_nxt = r_rep_cnt - REP_ONE;
                        w_pending_nxt = r_mask;
                    end else if (w_accept_load) begin
                        // Back-to-back request taken on the completion cycle
                        w_data_nxt    = data_in;
                        w_mask_nxt    = lane_mask_in;
                        w_pending_nxt = lane_mask_in;
                        w_rep_cnt_nxt = repeat_in;
                    end else begin
                        w_state_nxt   = BCAST_IDLE;
                        w_pending_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt   = BCAST_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= BCAST_IDLE;
            r_data    <= '0;
            r_mask    <= '0;
            r_pending <= '0;
            r_rep_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_mask    <= w_mask_nxt;
            r_pending <= w_pending_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end

    // Lane fan-out: captured word on masked lanes, zero elsewhere
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_mask[i]) begin
                data_out[i*DATA_WIDTH +: DATA_WIDTH] = r_data;
            end
        end
    end

    // Status outputs
    always_comb begin
        valid_out = r_pending;
        beat_done = w_beat_complete;
        busy      = w_in_drive;
        dbg_state = r_state;
    end

endmodule : vector_broadcast_unit

// File: tb/tb_vector_broadcast_unit.sv
// Directed testbench for vector_broadcast_unit (16 lanes x 16 bits).
module tb_vector_broadcast_unit;
    import npu_definitions::*;

    localparam int DW = 16;
    localparam int NL = 16;
    localparam int RW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     data_in;
    logic [NL-1:0]     lane_mask_in;
    logic [RW-1:0]     repeat_in;
    logic              valid_in;
    logic              ready_in;
    logic [NL*DW-1:0]  data_out;
    logic [NL-1:0]     valid_out;
    logic [NL-1:0]     ready_out;
    logic              beat_done;
    logic              busy;
    bcast_state_e      dbg_state;

    int checks   = 0;
    int failures = 0;

    vector_broadcast_unit #(
        .DATA_WIDTH (DW),
        .NUM_LANES  (NL),
        .REP_WIDTH  (RW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .lane_mask_in (lane_mask_in),
        .repeat_in    (repeat_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .beat_done    (beat_done),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one cycle; inputs are then changed 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes
    task automatic settle();
        #1;
    endtask

    function automatic logic [DW-1:0] lane(input logic [NL*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; lane_mask_in = '0;
        repeat_in = '0; ready_out = '1;
        tick(); tick();
        rst_n = 1'b1;
        settle();
        checks++; if (valid_out !== 16'h0000) begin failures++; $display("FAIL reset_valid_out got=%h exp=0000", valid_out); end
        checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL reset_ready_in got=%b exp=1", ready_in); end
        checks++; if (busy !== 1'b0 || beat_done !== 1'b0) begin failures++; $display("FAIL reset_busy_beat got=%b%b exp=00", busy, beat_done); end
        checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if (dbg_state !== BCAST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, BCAST_IDLE); end
    endtask

    task automatic test_single_beat();
        data_in = 16'h00A5; lane_mask_in = 16'hFFFF; repeat_in = 4'd0;
        valid_in = 1'b1; ready_out = '0;
        settle();
        checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL single_ready_before got=%b exp=1", ready_in); end
        tick();
        valid_in = 1'b0; ready_out = 16'hFFFF;
        settle();
        checks++; if (valid_out !== 16'hFFFF) begin failures++; $display("FAIL single_valid_out got=%h exp=ffff", valid_out); end
        checks++; if (data_out !== {NL{16'h00A5}}) begin failures++; $display("FAIL single_data_out got=%h exp=all 00a5", data_out); end
        checks++; if (beat_done !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_beat_busy got=%b%b exp=11", beat_done, busy); end
        tick();
        checks++; if (busy !== 1'b0 || ready_in !== 1'b1 || valid_out !== 16'h0) begin
            failures++; $display("FAIL single_idle_after got busy=%b ready_in=%b valid=%h exp 0 1 0000", busy, ready_in, valid_out); end
    endtask

    task automatic test_stepwise_lanes();
        logic [NL-1:0] exp_v [4];
        exp_v[0] = 16'h000F; exp_v[1] = 16'h000E; exp_v[2] = 16'h000C; exp_v[3] = 16'h0008;
        data_in = 16'h0055; lane_mask_in = 16'h000F; repeat_in = 4'd0;
        valid_in = 1'b1; ready_out = '0;
        tick();
        valid_in = 1'b0; data_in = 16'hDEAD;
        settle();
        checks++; if (lane(data_out, 0) !== 16'h0055 || lane(data_out, 4) !== 16'h0000) begin
            failures++; $display("FAIL step_lanes got l0=%h l4=%h exp 0055 0000", lane(data_out, 0), lane(data_out, 4)); end
        for (int k = 0; k < 4; k++) begin
            ready_out = 16'h0001 << k;
            settle();
            checks++; if (valid_out !== exp_v[k]) begin failures++; $display("FAIL step_valid_%0d got=%h exp=%h", k, valid_out, exp_v[k]); end
            checks++; if (beat_done !== (k == 3)) begin failures++; $display("FAIL step_beat_%0d got=%b exp=%b", k, beat_done, (k == 3)); end
            tick();
        end
        ready_out = '0;
        settle();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL step_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_repeat();
        int pulses = 0;
        data_in = 16'h7777; lane_mask_in = 16'h0003; repeat_in = 4'd2;
        valid_in = 1'b1; ready_out = 16'hFFFF;
        tick();
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            if (beat_done === 1'b1) pulses++;
            checks++; if (valid_out !== 16'h0003 || beat_done !== 1'b1) begin
                failures++; $display("FAIL repeat_beat_%0d got valid=%h beat=%b exp 0003 1", k, valid_out, beat_done); end
            checks++; if (ready_in !== (k == 2)) begin failures++; $display("FAIL repeat_ready_%0d got=%b exp=%b", k, ready_in, (k == 2)); end
            tick();
        end
        settle();
        if (beat_done === 1'b1) pulses++;
        checks++; if (pulses != 3 || busy !== 1'b0) begin failures++; $display("FAIL repeat_end got pulses=%0d busy=%b exp 3 0", pulses, busy); end
    endtask

    task automatic test_back_to_back();
        data_in = 16'h5A5A; lane_mask_in = 16'h0003; repeat_in = 4'd0;
        valid_in = 1'b1; ready_out = '0;
        tick();
        data_in = 16'h1234; lane_mask_in = 16'h00F0; repeat_in = 4'd0;
        settle();
        checks++; if (ready_in !== 1'b0) begin failures++; $display("FAIL b2b_ready_blocked got=%b exp=0", ready_in); end
        checks++; if (lane(data_out, 0) !== 16'h5A5A) begin failures++; $display("FAIL b2b_hold_data got=%h exp=5a5a", lane(data_out, 0)); end
        tick();
        ready_out = 16'hFFFF;
        settle();
        checks++; if (beat_done !== 1'b1 || ready_in !== 1'b1) begin
            failures++; $display("FAIL b2b_complete got beat=%b ready_in=%b exp 1 1", beat_done, ready_in); end
        tick();
        valid_in = 1'b0;
        settle();
        checks++; if (valid_out !== 16'h00F0 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_second_valid got valid=%h busy=%b exp 00f0 1", valid_out, busy); end
        checks++; if (lane(data_out, 4) !== 16'h1234 || lane(data_out, 0) !== 16'h0000) begin
            failures++; $display("FAIL b2b_second_data got l4=%h l0=%h exp 1234 0000", lane(data_out, 4), lane(data_out, 0)); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_zero_mask();
        data_in = 16'hBEEF; lane_mask_in = 16'h0000; repeat_in = 4'd3;
        valid_in = 1'b1; ready_out = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (ready_in !== 1'b1 || valid_out !== 16'h0 || beat_done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL zero_mask_%0d got ready_in=%b valid=%h beat=%b busy=%b exp 1 0000 0 0",
                                     k, ready_in, valid_out, beat_done, busy); end
            tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_beat();
        data_in = 16'h0F0F; lane_mask_in = 16'h00F0; repeat_in = 4'd1;
        valid_in = 1'b1; ready_out = '0;
        tick();
        valid_in = 1'b0;
        settle();
        checks++; if (valid_out !== 16'h00F0) begin failures++; $display("FAIL midrst_pending got=%h exp=00f0", valid_out); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ready_out = 16'hFFFF;
        settle();
        checks++; if (valid_out !== 16'h0 || ready_in !== 1'b1 || busy !== 1'b0 || beat_done !== 1'b0) begin
            failures++; $display("FAIL midrst_after got valid=%h ready_in=%b busy=%b beat=%b exp 0000 1 0 0",
                                 valid_out, ready_in, busy, beat_done); end
        checks++; if (data_out !== '0) begin failures++; $display("FAIL midrst_data got=%h exp=0", data_out); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_stepwise_lanes();
        test_repeat();
        test_back_to_back();
        test_zero_mask();
        test_reset_mid_beat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vector_broadcast_unit

// File: doc/vector_broadcast_unit.md
VECTOR_BROADCAST_UNIT -- requirements
Module: vector_broadcast_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning width of one data word.
REQ-002 SHALL have parameter NUM_LANES, default 16, meaning number of output lanes (2..64).
REQ-003 SHALL have parameter REP_WIDTH, default 4, meaning width of the repeat-count field.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-006 SHALL have port data_in  input  DATA_WIDTH  word to broadcast.
REQ-007 SHALL have port lane_mask_in  input  NUM_LANES  lanes that receive the word.
REQ-008 SHALL have port repeat_in  input  REP_WIDTH  extra repetitions (beats = repeat_in+1).
REQ-009 SHALL have port valid_in  input  1  request valid.
REQ-010 SHALL have port ready_in  output  1  unit can accept a request.
REQ-011 SHALL have port data_out  output  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port valid_out  output  NUM_LANES  per-lane valid.
REQ-013 SHALL have port ready_out  input  NUM_LANES  per-lane ready.
REQ-014 SHALL have port beat_done  output  1  one-cycle pulse when every masked lane has taken the current beat.
REQ-015 SHALL have port busy  output  1  high while in DRIVE.

Function
REQ-016 SHALL implement states IDLE and DRIVE; ready_in = (state==IDLE) or (DRIVE, last beat, and every pending lane accepts this cycle).
REQ-017 SHALL accept a request when valid_in && ready_in; it captures data_in, lane_mask_in and repeat_in, sets pending = lane_mask_in and rep_cnt = repeat_in, and enters or stays in DRIVE.
REQ-018 SHALL present captured data on every lane of data_out from the cycle after acceptance (latency 1); unmasked lanes drive zero.
REQ-019 SHALL drive valid_out = pending; lane i handshakes when valid_out[i] && ready_out[i], and the same cycle clears pending[i].
REQ-020 SHALL let lanes accept independently in any order and any cycle; a lane already accepted shall not reassert valid until the next beat.
REQ-021 SHALL complete a beat when all pending bits are cleared (including the ones clearing this cycle); it pulses beat_done in that cycle.
REQ-022 SHALL, on beat completion with rep_cnt > 0, decrement rep_cnt and reload pending = captured mask on the next cycle, with no bubble.
REQ-023 SHALL, on beat completion with rep_cnt == 0, return to IDLE, unless a new request is accepted in the same cycle; in that case it reloads from the new request (back-to-back, zero idle cycles).
REQ-024 SHALL accept a request with lane_mask_in == 0 and discard it: no valid_out, no beat_done, state unchanged, ready_in stays high.
REQ-025 SHALL hold data_out, mask and rep_cnt stable in DRIVE regardless of valid_in/data_in.
REQ-026 SHALL treat ready_out on unmasked or already-cleared lanes as don't-care.

Reset
REQ-027 SHALL, on rst_n low at a clock edge, set state IDLE, pending 0, rep_cnt 0, data register 0, valid_out 0, beat_done 0, busy 0, ready_in 1.
REQ-028 SHALL make reset asserted mid-beat abandon the beat silently; no beat_done is produced for it.

Structure
REQ-029 SHALL take the state encoding (BCAST_IDLE, BCAST_DRIVE) and default parameter values from the shared npu_definitions package.
REQ-030 SHALL be a single module with no sub-modules; the pending-mask update is combinational next-state logic in the same file.

Verification
REQ-031 SHALL cover: NUM_LANES=16, data 0x00A5, mask 0xFFFF, repeat 0, all ready_out=1 -> valid_out=0xFFFF one cycle after accept, beat_done same cycle, IDLE next.
REQ-032 SHALL cover: mask 0x000F, ready_out lanes 0..3 asserted on separate cycles -> valid_out steps 0xF, 0xE, 0xC, 0x8; beat_done only on lane 3's cycle.
REQ-033 SHALL cover: repeat 2, mask 0x0003, ready always 1 -> exactly 3 beat_done pulses on consecutive cycles, then IDLE.
REQ-034 SHALL cover: second request (data 0x1234) held valid during the last beat -> accepted on the completion cycle, new data on lanes the next cycle, no gap.
REQ-035 SHALL cover: mask 0x0000 -> ready_in stays 1, valid_out stays 0, no beat_done.
REQ-036 SHALL cover: rst_n low for one cycle mid-beat with pending 0x00F0 -> next cycle valid_out 0, ready_in 1, busy 0.
